// File: rtl/usb_rx_bit_decoder.sv
// Full-speed USB receive bit path: recovers bit timing from line edges,
// NRZI-decodes J/K samples, checks SYNC, removes stuff bits, detects EOP,
// and assembles LSB-first bytes for the packet layer.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PHASE_MAX = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SMP = PW'(CLKS_PER_BIT / 2);

  // Line states as {dp, dm}
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    line_q;
  logic          prevk_q, prevk_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [2:0]    ones_q, ones_d;
  logic          eop2_q, eop2_d;
  logic [2:0]    jcnt_q, jcnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          active_q, active_d;
  logic          eop_q, eop_d;
  logic          err_q, err_d;

  logic [1:0]    pair;
  logic          edge_seen;
  logic          smp;
  logic          is_j, is_k, is_se0, is_se1;
  logic          dec;
  logic [7:0]    byte_next;
  logic          go_err;

  // Bit-timing recovery: any line transition restarts the phase so the
  // sample point stays centred even when the transmitter drifts.
  always_comb begin
    pair      = {dp_in, dm_in};
    edge_seen = (pair != line_q);
    if (edge_seen || (phase_q == PHASE_MAX)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
    smp    = (phase_q == PHASE_SMP);
    is_j   = (pair == LS_J);
    is_k   = (pair == LS_K);
    is_se0 = (pair == LS_SE0);
    is_se1 = (pair == LS_SE1);
  end

  // Receive FSM: NRZI decode, SYNC check, unstuffing, byte assembly, EOP.
  always_comb begin
    state_d   = state_q;
    prevk_d   = prevk_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    ones_d    = ones_q;
    eop2_d    = eop2_q;
    jcnt_d    = jcnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;
    eop_d     = 1'b0;
    err_d     = 1'b0;
    go_err    = 1'b0;
    // A bit is a 1 when the line stays in the same J/K state
    dec       = (is_k == prevk_q);
    byte_next = {dec, shift_q[7:1]};

    if (smp && (is_j || is_k)) begin
      prevk_d = is_k;
    end

    case (state_q)
      S_IDLE: begin
        // Reference level is held at J while idle so the first K decodes as 0
        prevk_d = 1'b0;
        if (smp) begin
          if (is_k) begin
            prevk_d  = 1'b1;
            shift_d  = 8'h00;  // first SYNC bit (a 0) already sits in bit 7
            bitcnt_d = 3'd1;
            ones_d   = 3'd0;
            state_d  = S_SYNC;
          end else if (is_se1) begin
            go_err = 1'b1;
          end
        end
      end

      S_SYNC: begin
        if (smp) begin
          if (is_se0 || is_se1) begin
            go_err = 1'b1;
          end else begin
            shift_d  = byte_next;
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) begin
              if (byte_next == SYNC_BYTE) begin
                state_d  = S_DATA;
                active_d = 1'b1;
                shift_d  = 8'h00;
                bitcnt_d = 3'd0;
                ones_d   = 3'd0;
              end else begin
                go_err = 1'b1;
              end
            end
          end
        end
      end

      S_DATA: begin
        if (smp) begin
          if (is_se1) begin
            go_err = 1'b1;
          end else if (is_se0) begin
            eop2_d  = 1'b0;
            state_d = S_EOP;
          end else if (ones_q == 3'd6) begin
            // Bit after six ones must be a stuffed 0; drop it
            if (dec) begin
              go_err = 1'b1;
            end else begin
              ones_d = 3'd0;
            end
          end else begin
            ones_d   = dec ? (ones_q + 1'b1) : 3'd0;
            shift_d  = byte_next;
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) begin
              data_d  = byte_next;
              valid_d = 1'b1;
            end
          end
        end
      end

      S_EOP: begin
        if (smp) begin
          if (is_se0 && !eop2_q) begin
            eop2_d = 1'b1;
          end else if (is_j && eop2_q && (bitcnt_q == 3'd0)) begin
            eop_d    = 1'b1;
            active_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end
      end

      S_ERR: begin
        // Recover only after eight consecutive J samples
        if (smp) begin
          if (is_j) begin
            if (jcnt_q == 3'd7) begin
              jcnt_d  = 3'd0;
              state_d = S_IDLE;
            end else begin
              jcnt_d = jcnt_q + 1'b1;
            end
          end else begin
            jcnt_d = 3'd0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_err) begin
      state_d  = S_ERR;
      err_d    = 1'b1;
      active_d = 1'b0;
      jcnt_d   = 3'd0;
    end

    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      shift_d  = 8'h00;
      bitcnt_d = 3'd0;
      ones_d   = 3'd0;
      prevk_d  = 1'b0;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      line_q   <= LS_J;
      prevk_q  <= 1'b0;
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      ones_q   <= 3'd0;
      eop2_q   <= 1'b0;
      jcnt_q   <= 3'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      line_q   <= pair;
      prevk_q  <= prevk_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      ones_q   <= ones_d;
      eop2_q   <= eop2_d;
      jcnt_q   <= jcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      eop_q    <= eop_d;
      err_q    <= err_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_active = active_q;
  assign rx_eop    = eop_q;
  assign rx_error  = err_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder: drives NRZI-encoded packets on
// D+/D- and checks recovered bytes, strobe spacing and packet flags.
module tb_usb_rx_bit_decoder;

  localparam int CPB = 8;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_SE1 = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       dp, dm;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_eop, rx_error;

  usb_rx_bit_decoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .dp_in    (dp),
    .dm_in    (dm),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_active(rx_active),
    .rx_eop   (rx_eop),
    .rx_error (rx_error)
  );

  always #5 clk = ~clk;

  // Event recorder, sampled on the falling edge
  int         cyc      = 0;
  int         eop_cnt  = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  int         act_cnt  = 0;
  logic [7:0] vdata[$];
  int         vcyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid) begin
      vdata.push_back(rx_data);
      vcyc.push_back(cyc);
    end
    if (rx_eop)   eop_cnt  <= eop_cnt + 1;
    if (rx_error) err_cnt  <= err_cnt + 1;
    if (rx_valid && rx_eop) both_cnt <= both_cnt + 1;
    if (rx_active) act_cnt <= act_cnt + 1;
  end

  int   ncmp = 0;
  int   nerr = 0;
  logic lvl_k;
  int   vb, eb, rb, ab;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    vb = vdata.size();
    eb = eop_cnt;
    rb = err_cnt;
    ab = act_cnt;
  endtask

  task automatic drive(input logic [1:0] ls, input int n);
    dp = ls[1];
    dm = ls[0];
    repeat (n) @(negedge clk);
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it
  task automatic send_bit(input logic b, input int n);
    if (!b) lvl_k = ~lvl_k;
    drive(lvl_k ? LS_K : LS_J, n);
  endtask

  task automatic send_byte(input logic [7:0] b, input int n);
    for (int i = 0; i < 8; i++) send_bit(b[i], n);
  endtask

  task automatic send_sync();
    lvl_k = 1'b0;
    send_byte(8'h80, CPB);
  endtask

  task automatic send_eop();
    drive(LS_SE0, 2 * CPB);
    drive(LS_J, CPB);
    lvl_k = 1'b0;
  endtask

  task automatic idle(input int nbits);
    drive(LS_J, nbits * CPB);
    lvl_k = 1'b0;
  endtask

  function automatic logic [7:0] vd(input int i);
    return (i < vdata.size()) ? vdata[i] : 8'hxx;
  endfunction

  function automatic int vc(input int i);
    return (i < vcyc.size()) ? vcyc[i] : -1;
  endfunction

  initial begin
    rst = 1'b1; dp = 1'b1; dm = 1'b0; lvl_k = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rx_data, rx_valid, rx_active, rx_eop, rx_error}, 12'h000);
    rst = 1'b0;
    idle(6);
    chk("idle_quiet", act_cnt + eop_cnt + err_cnt + vdata.size(), 0);

    // Basic packet: A5, 3C
    snap();
    send_sync();
    chk("basic_active_after_sync", rx_active, 1);
    send_byte(8'hA5, CPB);
    send_byte(8'h3C, CPB);
    send_eop();
    idle(2);
    chk("basic_nvalid", vdata.size() - vb, 2);
    chk("basic_byte0", vd(vb), 8'hA5);
    chk("basic_byte1", vd(vb + 1), 8'h3C);
    chk("basic_spacing", vc(vb + 1) - vc(vb), 64);
    chk("basic_eop", eop_cnt - eb, 1);
    chk("basic_noerr", err_cnt - rb, 0);
    chk("basic_active_low", rx_active, 0);
    chk("valid_eop_overlap", both_cnt, 0);

    // Reset mid-packet, then a fresh packet
    send_sync();
    send_bit(1'b1, CPB); send_bit(1'b0, CPB); send_bit(1'b1, CPB); send_bit(1'b1, CPB);
    chk("rst_active_before", rx_active, 1);
    chk("rst_data_holds", rx_data, 8'h3C);
    snap();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs", {rx_data, rx_valid, rx_active, rx_eop, rx_error}, 12'h000);
    drive(LS_J, 2 * CPB);
    rst = 1'b0;
    idle(4);
    chk("rst_no_flags", (eop_cnt - eb) + (err_cnt - rb) + (vdata.size() - vb), 0);
    snap();
    send_sync();
    send_byte(8'hC3, CPB);
    send_eop();
    idle(2);
    chk("rst_fresh_nvalid", vdata.size() - vb, 1);
    chk("rst_fresh_byte", vd(vb), 8'hC3);
    chk("rst_fresh_eop", eop_cnt - eb, 1);

    // Stuffing: 00, FF (stuff 0 after six 1s), 01
    snap();
    send_sync();
    send_byte(8'h00, CPB);
    for (int i = 0; i < 6; i++) send_bit(1'b1, CPB);
    send_bit(1'b0, CPB);
    send_bit(1'b1, CPB);
    send_bit(1'b1, CPB);
    send_byte(8'h01, CPB);
    send_eop();
    idle(2);
    chk("stuff_nvalid", vdata.size() - vb, 3);
    chk("stuff_byte_ff", vd(vb + 1), 8'hFF);
    chk("stuff_byte_01", vd(vb + 2), 8'h01);
    chk("stuff_spacing_ff", vc(vb + 1) - vc(vb), 72);
    chk("stuff_spacing_01", vc(vb + 2) - vc(vb + 1), 64);
    chk("stuff_noerr", err_cnt - rb, 0);
    chk("stuff_eop", eop_cnt - eb, 1);

    // Stuff error: seven 1s in a row, then recovery via J idle
    snap();
    send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b1, CPB);
    idle(10);
    chk("stufferr_error", err_cnt - rb, 1);
    chk("stufferr_novalid", vdata.size() - vb, 0);
    chk("stufferr_active_low", rx_active, 0);
    chk("stufferr_noeop", eop_cnt - eb, 0);
    snap();
    send_sync();
    send_byte(8'h81, CPB);
    send_eop();
    idle(2);
    chk("stufferr_recover_byte", vd(vb), 8'h81);
    chk("stufferr_recover_eop", eop_cnt - eb, 1);

    // Bad SYNC: KJKJKJKJ
    snap();
    lvl_k = 1'b0;
    send_byte(8'h00, CPB);
    idle(10);
    chk("badsync_error", err_cnt - rb, 1);
    chk("badsync_never_active", act_cnt - ab, 0);
    chk("badsync_novalid", vdata.size() - vb, 0);

    // SE1 in the middle of a byte
    snap();
    send_sync();
    send_bit(1'b1, CPB); send_bit(1'b0, CPB); send_bit(1'b1, CPB);
    drive(LS_SE1, CPB);
    idle(10);
    chk("se1_error", err_cnt - rb, 1);
    chk("se1_novalid", vdata.size() - vb, 0);
    chk("se1_active_low", rx_active, 0);

    // Drift: 16 bits at 7 clocks, 16 at 9, then EOP after a 4-bit partial
    snap();
    send_sync();
    send_byte(8'h00, 7);
    send_byte(8'h55, 7);
    send_byte(8'h33, 9);
    send_byte(8'h2D, 9);
    send_bit(1'b0, CPB); send_bit(1'b1, CPB); send_bit(1'b0, CPB); send_bit(1'b0, CPB);
    send_eop();
    idle(10);
    chk("drift_nvalid", vdata.size() - vb, 4);
    chk("drift_byte0", vd(vb), 8'h00);
    chk("drift_byte1", vd(vb + 1), 8'h55);
    chk("drift_byte2", vd(vb + 2), 8'h33);
    chk("drift_byte3", vd(vb + 3), 8'h2D);
    chk("drift_partial_error", err_cnt - rb, 1);
    chk("drift_partial_noeop", eop_cnt - eb, 0);
    chk("drift_active_low", rx_active, 0);
    chk("valid_eop_overlap_end", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
